// File: rtl/flash_audio_player.sv
// flash_audio_player
//   Streams SAMPLE_W-bit audio samples out of DATA_W-bit flash words read over
//   Avalon-MM. Each word holds N = DATA_W/SAMPLE_W lanes. One lane is presented
//   per sample_tick. The next word is prefetched as soon as the current one has
//   been fully played. Keyboard ASCII commands control playback: play, pause,
//   forward, backward, restart and loop toggle.
//
// Ports
//   CLK_50M, RESET_N         : clock, asynchronous active-low reset
//   sample_tick              : one-cycle pulse per audio sample period
//   kbd_received_ascii_code  : decoded key, taken on a rising edge of kbd_data_ready
//   kbd_data_ready           : key-valid level
//   flash_mem_*              : Avalon-MM read master (one read outstanding at a time)
//   audio_data               : current sample, registered
//   playing/direction/loop_en: playback status
//   underrun                 : one-cycle pulse when a tick finds no word ready
module flash_audio_player #(
  parameter int                ADDR_W       = 23,
  parameter int                DATA_W       = 32,
  parameter int                SAMPLE_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR   = '0,
  parameter logic [ADDR_W-1:0] END_ADDR     = ADDR_W'(23'h7FFFF),
  parameter logic              LOOP_DEFAULT = 1'b1
) (
  input  logic                CLK_50M,
  input  logic                RESET_N,
  input  logic                sample_tick,
  input  logic [7:0]          kbd_received_ascii_code,
  input  logic                kbd_data_ready,
  input  logic                flash_mem_waitrequest,
  input  logic                flash_mem_readdatavalid,
  input  logic [DATA_W-1:0]   flash_mem_readdata,
  output logic                flash_mem_read,
  output logic [ADDR_W-1:0]   flash_mem_address,
  output logic [SAMPLE_W-1:0] audio_data,
  output logic                playing,
  output logic                direction,
  output logic                loop_en,
  output logic                underrun
);

  localparam int N  = DATA_W / SAMPLE_W;
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(N - 1);
  localparam logic [LW-1:0] LANE_ONE  = LW'(1);

  localparam logic [7:0] KEY_PLAY    = 8'h45;  // 'E'
  localparam logic [7:0] KEY_PAUSE   = 8'h44;  // 'D'
  localparam logic [7:0] KEY_FWD     = 8'h46;  // 'F'
  localparam logic [7:0] KEY_BWD     = 8'h42;  // 'B'
  localparam logic [7:0] KEY_RESTART = 8'h52;  // 'R'
  localparam logic [7:0] KEY_LOOP    = 8'h4C;  // 'L'

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT_DATA,
    S_PLAY,
    S_ADVANCE
  } state_t;

  state_t r_state, w_state_nxt;

  logic                         r_kbd_q;
  logic                         w_cmd;
  logic                         r_playing, r_direction, r_loop_en, r_restart;
  logic                         w_play_c, w_dir_c, w_loop_c, w_restart_c;
  logic                         r_read;
  logic [ADDR_W-1:0]            r_addr, w_addr_adv;
  logic                         w_at_bound, w_stop;
  logic [N-1:0][SAMPLE_W-1:0]   r_word, w_rdword;
  logic                         r_word_fwd;
  logic [LW-1:0]                r_lane;
  logic [SAMPLE_W-1:0]          r_audio;
  logic                         r_underrun, r_tick_pending;
  logic                         w_emit, w_last, w_underrun;

  // Lane i sits at bits [i*SAMPLE_W +: SAMPLE_W]; the packed view matches that.
  assign w_rdword = flash_mem_readdata;

  assign w_cmd = kbd_data_ready & ~r_kbd_q;

  // Command decode. Everything downstream uses these post-command values, so
  // a command and a tick in the same cycle see the command applied first.
  always_comb begin
    w_play_c    = r_playing;
    w_dir_c     = r_direction;
    w_loop_c    = r_loop_en;
    w_restart_c = r_restart;
    if (w_cmd) begin
      case (kbd_received_ascii_code)
        KEY_PLAY:    w_play_c = 1'b1;
        KEY_PAUSE:   w_play_c = 1'b0;
        KEY_FWD:     w_dir_c  = 1'b1;
        KEY_BWD:     w_dir_c  = 1'b0;
        KEY_RESTART: begin
          w_restart_c = 1'b1;
          w_play_c    = 1'b1;
        end
        KEY_LOOP:    w_loop_c = ~r_loop_en;
        default: ;
      endcase
    end
  end

  // Lane order is frozen per word in r_word_fwd, independent of later 'F'/'B'.
  assign w_last     = r_word_fwd ? (r_lane == LANE_LAST) : (r_lane == '0);
  assign w_emit     = (r_state == S_PLAY) && w_play_c && (sample_tick || r_tick_pending);
  assign w_underrun = sample_tick && w_play_c && (r_state != S_PLAY);

  // Next word address. A range end always goes to the start for the current
  // direction; without loop mode that also stops playback.
  always_comb begin
    w_addr_adv = r_addr;
    w_stop     = 1'b0;
    w_at_bound = w_dir_c ? (r_addr == END_ADDR) : (r_addr == START_ADDR);
    if (w_restart_c) begin
      w_addr_adv = w_dir_c ? START_ADDR : END_ADDR;
    end else if (w_at_bound) begin
      w_addr_adv = w_dir_c ? START_ADDR : END_ADDR;
      w_stop     = ~w_loop_c;
    end else if (w_dir_c) begin
      w_addr_adv = r_addr + 1'b1;
    end else begin
      w_addr_adv = r_addr - 1'b1;
    end
  end

  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_REQ;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // r_read is low in the first cycle after reset; only a presented
      // request may be accepted.
      S_REQ:       if (r_read && !flash_mem_waitrequest) w_state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: if (flash_mem_readdatavalid)          w_state_nxt = S_PLAY;
      S_PLAY:      if (w_emit && w_last)                 w_state_nxt = S_ADVANCE;
      S_ADVANCE:   w_state_nxt = S_REQ;
      default:     w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_kbd_q        <= 1'b0;
      r_playing      <= 1'b0;
      r_direction    <= 1'b1;
      r_loop_en      <= LOOP_DEFAULT;
      r_restart      <= 1'b0;
      r_read         <= 1'b0;
      r_addr         <= START_ADDR;
      r_word         <= '0;
      r_word_fwd     <= 1'b1;
      r_lane         <= '0;
      r_audio        <= '0;
      r_underrun     <= 1'b0;
      r_tick_pending <= 1'b0;
    end else begin
      r_kbd_q     <= kbd_data_ready;
      r_playing   <= w_play_c;
      r_direction <= w_dir_c;
      r_loop_en   <= w_loop_c;
      r_restart   <= w_restart_c;
      r_read      <= (w_state_nxt == S_REQ);
      r_underrun  <= w_underrun;

      // A single missed tick is remembered; a pause discards it.
      if (!w_play_c)       r_tick_pending <= 1'b0;
      else if (w_underrun) r_tick_pending <= 1'b1;
      else if (w_emit)     r_tick_pending <= 1'b0;

      case (r_state)
        S_WAIT_DATA: begin
          if (flash_mem_readdatavalid) begin
            r_word     <= w_rdword;
            r_word_fwd <= w_dir_c;
            r_lane     <= w_dir_c ? '0 : LANE_LAST;
          end
        end
        S_PLAY: begin
          if (w_emit && !w_last)
            r_lane <= r_word_fwd ? (r_lane + LANE_ONE) : (r_lane - LANE_ONE);
        end
        S_ADVANCE: begin
          r_addr    <= w_addr_adv;
          r_restart <= 1'b0;
          if (w_stop) r_playing <= 1'b0;
        end
        default: ;
      endcase

      if (!w_play_c)   r_audio <= '0;
      else if (w_emit) r_audio <= r_word[r_lane];
    end
  end

  assign flash_mem_read    = r_read;
  assign flash_mem_address = r_addr;
  assign audio_data        = r_audio;
  assign playing           = r_playing;
  assign direction         = r_direction;
  assign loop_en           = r_loop_en;
  assign underrun          = r_underrun;

endmodule

// File: tb/tb_flash_audio_player.sv
// Bench for flash_audio_player. It models the flash as a randomly-delayed
// Avalon slave over a small address range. Random ticks and commands feed a
// word/lane-level playback model. A monitor pops the expected state whenever
// a tick or a command edge reaches the DUT. A directed underrun episode and
// asynchronous reset checks close the run.
module tb_flash_audio_player;
  localparam int          ADDR_W   = 23;
  localparam int          DATA_W   = 32;
  localparam int          SAMPLE_W = 16;
  localparam int          N        = DATA_W / SAMPLE_W;
  localparam int          START    = 2;
  localparam int          ENDA     = 6;

  logic                clk, rst_n, tick, kbd, wr, rdv;
  logic [7:0]          code;
  logic [DATA_W-1:0]   rdata;
  logic                read, playing, direction, loop_en, underrun;
  logic [ADDR_W-1:0]   addr;
  logic [SAMPLE_W-1:0] audio;

  flash_audio_player #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W),
    .START_ADDR(ADDR_W'(START)), .END_ADDR(ADDR_W'(ENDA)), .LOOP_DEFAULT(1'b1)
  ) dut (
    .CLK_50M(clk), .RESET_N(rst_n), .sample_tick(tick),
    .kbd_received_ascii_code(code), .kbd_data_ready(kbd),
    .flash_mem_waitrequest(wr), .flash_mem_readdatavalid(rdv),
    .flash_mem_readdata(rdata), .flash_mem_read(read),
    .flash_mem_address(addr), .audio_data(audio), .playing(playing),
    .direction(direction), .loop_en(loop_en), .underrun(underrun)
  );

  typedef struct {
    logic [SAMPLE_W-1:0] audio;
    bit                  play, dir, loop, urun, chk_addr;
    logic [ADDR_W-1:0]   addr;
  } exp_t;

  exp_t         q[$];
  int           checks = 0, errors = 0;
  logic [DATA_W-1:0] mem [0:ENDA];

  // playback model
  int                  m_addr, m_pos;
  bit                  m_dir, m_wdir, m_play, m_loop, m_restart;
  logic [SAMPLE_W-1:0] m_audio;

  int  hold_len = 0;     // written by stimulus only
  bit  hold_active = 0;  // written by flash model only
  bit  hold_done = 0;
  int  ucnt = 0;
  bit  kprev = 0, mon_ev = 0;
  logic [ADDR_W-1:0] fl_a;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Avalon slave: random accept delay, random read latency, optional long hold.
  initial begin : flash
    wr = 1; rdv = 0; rdata = '0;
    forever begin
      @(negedge clk);
      rdv = 0;
      if (read === 1'b1) begin
        if (hold_len > 0 && !hold_done) begin
          hold_done = 1; hold_active = 1;
          repeat (hold_len) @(negedge clk);
          hold_active = 0;
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        wr = 0; fl_a = addr;
        @(negedge clk); wr = 1;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        chk("rd_addr_in_range", (fl_a >= ADDR_W'(START)) && (fl_a <= ADDR_W'(ENDA)), 1);
        rdata = mem[fl_a]; rdv = 1;
      end
    end
  end

  initial begin : ucounter
    forever begin
      @(negedge clk);
      if (underrun === 1'b1) ucnt++;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      mon_ev = (tick === 1'b1) || (kbd === 1'b1 && !kprev);
      kprev  = (kbd === 1'b1);
      if (mon_ev) begin
        @(negedge clk);
        if (q.size() == 0) chk("sb_empty", 1, 0);
        else begin
          e = q.pop_front();
          chk("audio", audio, e.audio);
          chk("playing", playing, e.play);
          chk("direction", direction, e.dir);
          chk("loop_en", loop_en, e.loop);
          chk("underrun", underrun, e.urun);
          if (e.chk_addr) chk("address", addr, e.addr);
        end
      end
    end
  end

  function automatic void advance();
    if (m_restart) begin
      m_addr = m_dir ? START : ENDA;
      m_restart = 0;
    end else if (m_dir ? (m_addr == ENDA) : (m_addr == START)) begin
      m_addr = m_dir ? START : ENDA;
      if (!m_loop) begin m_play = 0; m_audio = '0; end
    end else begin
      m_addr = m_dir ? m_addr + 1 : m_addr - 1;
    end
    m_pos  = 0;
    m_wdir = m_dir;
  endfunction

  function automatic void emit();
    logic [DATA_W-1:0] w;
    int lane;
    lane    = m_wdir ? m_pos : N - 1 - m_pos;
    w       = mem[m_addr];
    m_audio = w[lane*SAMPLE_W +: SAMPLE_W];
    m_pos++;
  endfunction

  task automatic do_tick();
    exp_t e;
    e.urun = 0; e.chk_addr = 0; e.addr = '0;
    e.play = m_play; e.dir = m_dir; e.loop = m_loop;
    if (m_play) emit();
    e.audio = m_audio;
    if (m_play && m_pos == N) advance();
    q.push_back(e);
    @(negedge clk) tick = 1;
    @(negedge clk) tick = 0;
  endtask

  task automatic do_cmd(input logic [7:0] c);
    exp_t e;
    case (c)
      8'h45: m_play = 1;
      8'h44: begin m_play = 0; m_audio = '0; end
      8'h46: m_dir = 1;
      8'h42: m_dir = 0;
      8'h52: begin m_restart = 1; m_play = 1; end
      8'h4C: m_loop = !m_loop;
      default: ;
    endcase
    e.audio = m_audio; e.play = m_play; e.dir = m_dir; e.loop = m_loop;
    e.urun = 0; e.chk_addr = 1; e.addr = ADDR_W'(m_addr);
    q.push_back(e);
    @(negedge clk); code = c; kbd = 1;
    repeat (3) @(negedge clk);
    kbd = 0;
  endtask

  initial begin : stim
    logic [7:0] cmds [0:8];
    logic [ADDR_W-1:0] held;
    exp_t e;
    int u0, bad;
    bit found;
    cmds = '{8'h45, 8'h44, 8'h46, 8'h42, 8'h52, 8'h4C, 8'h41, 8'h45, 8'h42};
    for (int i = 0; i <= ENDA; i++) mem[i] = $urandom;
    m_addr = START; m_pos = 0; m_dir = 1; m_wdir = 1; m_play = 0;
    m_loop = 1; m_restart = 0; m_audio = '0;
    rst_n = 0; tick = 0; kbd = 0; code = '0;

    repeat (3) @(negedge clk);
    chk("rst_read", read, 0);
    chk("rst_addr", addr, START);
    chk("rst_audio", audio, 0);
    chk("rst_playing", playing, 0);
    chk("rst_direction", direction, 1);
    chk("rst_loop_en", loop_en, 1);
    chk("rst_underrun", underrun, 0);
    rst_n = 1;
    repeat (30) @(negedge clk);

    // random playback
    do_cmd(8'h45);
    repeat (20) @(negedge clk);
    for (int it = 0; it < 150; it++) begin
      do_tick();
      repeat (20) @(negedge clk);
      if ($urandom_range(0, 2) == 0) do_cmd(cmds[$urandom_range(0, 8)]);
      repeat (15) @(negedge clk);
    end

    // underrun: stall the refill that follows the last lane of a word
    if (!m_loop) do_cmd(8'h4C);
    do_cmd(8'h45);
    repeat (20) @(negedge clk);
    for (int k = 0; k < N && m_pos != N - 1; k++) begin
      do_tick();
      repeat (30) @(negedge clk);
    end
    hold_len = 3000;
    do_tick();
    repeat (100) @(negedge clk);
    held = addr;
    chk("hold_read", read, 1);
    chk("hold_addr", addr, m_addr);
    u0 = ucnt;
    e.audio = m_audio; e.play = 1; e.dir = m_dir; e.loop = m_loop;
    e.urun = 1; e.chk_addr = 0; e.addr = '0;
    q.push_back(e);
    @(negedge clk) tick = 1;
    @(negedge clk) tick = 0;
    found = 0; bad = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk); #1;
      if (hold_active && (read !== 1'b1 || addr !== held)) bad++;
      if (rdv === 1'b1) begin found = 1; break; end
    end
    chk("refill_returned", found, 1);
    chk("hold_stable_violations", bad, 0);
    @(negedge clk);
    chk("audio_held_at_latch", audio, m_audio);
    emit();
    if (m_pos == N) advance();
    @(negedge clk);
    chk("pending_first_lane", audio, m_audio);
    chk("underrun_pulses", ucnt - u0, 1);
    for (int k = 0; k < 4; k++) begin
      repeat (30) @(negedge clk);
      do_tick();
    end
    repeat (10) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    chk("underrun_total", ucnt, 1);

    // asynchronous reset between clock edges
    @(negedge clk); #2 rst_n = 0; #1;
    chk("arst_read", read, 0);
    chk("arst_addr", addr, START);
    chk("arst_audio", audio, 0);
    chk("arst_playing", playing, 0);
    chk("arst_direction", direction, 1);
    chk("arst_loop_en", loop_en, 1);
    chk("arst_underrun", underrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/flash_audio_player.md
# flash_audio_player

Parametrised successor to the two-lane flash playback controller. It streams fixed-width audio samples from the on-board flash over the Avalon-MM read interface. Playback is controlled by keyboard ASCII commands, and one sample is presented per sample tick. It sits between the PS/2 keyboard decoder, the flash controller and the audio codec interface, all on CLK_50M. The sample tick arrives already synchronised as a one-cycle pulse from the shared edge detector. It generalises word/sample width, address range and loop mode, prefetches words, and has an underrun indication.

## Interface
- ADDR_W, 23, flash word-address width
- DATA_W, 32, flash read-data width
- SAMPLE_W, 16, audio sample width; DATA_W must be an integer multiple; N = DATA_W/SAMPLE_W lanes per word (N ≥ 1)
- START_ADDR, 0, first word of the playback range
- END_ADDR, 23'h7FFFF, last word of the playback range (END_ADDR ≥ START_ADDR)
- LOOP_DEFAULT, 1'b1, loop mode after reset
- CLK_50M  in  1  sole clock, all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-cycle pulse per audio sample period
- kbd_received_ascii_code  in  8  decoded key
- kbd_data_ready  in  1  level; a command is taken on its rising edge only
- flash_mem_waitrequest  in  1  Avalon waitrequest
- flash_mem_readdatavalid  in  1  Avalon read-data valid
- flash_mem_readdata  in  DATA_W  Avalon read data
- flash_mem_read  out  1  Avalon read request
- flash_mem_address  out  ADDR_W  current word address
- audio_data  out  SAMPLE_W  current sample, registered
- playing  out  1  1 = not paused
- direction  out  1  1 = forward, 0 = backward
- loop_en  out  1  current loop mode
- underrun  out  1  one-cycle pulse when a tick finds no word ready

## Operation
- **Keyboard commands.** Each command executes once per kbd_data_ready rising edge; the edge is detected with an internal registered copy. Unknown codes are ignored.
  - 0x45 'E': play.
  - 0x44 'D': pause.
  - 0x46 'F': forward.
  - 0x42 'B': backward.
  - 0x52 'R': restart. Sets restart_pending and play.
  - 0x4C 'L': toggle loop_en.
- **Lanes.** Lane i is flash_mem_readdata[i*SAMPLE_W +: SAMPLE_W].
  - Forward plays lanes 0..N-1.
  - Backward plays lanes N-1..0.
  - The lane order is fixed when the word is latched; a direction change takes effect from the next word.
- **FSM states: REQ, WAIT_DATA, PLAY, ADVANCE.**
  - REQ: drive flash_mem_read=1 with the address stable. Go to WAIT_DATA in the cycle where waitrequest=0, and deassert read in the following cycle.
  - WAIT_DATA: on readdatavalid, latch the whole word, set lane index to the first lane for the current direction, and go to PLAY.
  - PLAY: on sample_tick with playing=1, load audio_data with the indexed lane.
    - Step the index. After the last lane, go to ADVANCE.
    - If paused, ticks are ignored and the position is held.
  - ADVANCE, with restart_pending set: address = START_ADDR if forward, END_ADDR if backward; clear the flag.
  - ADVANCE, otherwise: forward adds 1, backward subtracts 1.
  - ADVANCE, at a range boundary (forward at END_ADDR, backward at START_ADDR):
    - loop_en=1: wrap to the opposite end.
    - loop_en=0: go to the range start for the current direction and clear playing.
  - ADVANCE always goes to REQ. This prefetches the next word immediately rather than waiting for a tick.
- **Pause output.** While playing=0, audio_data is forced to 0 from the cycle after the pause takes effect. Resuming continues at the held lane.
- **Underrun.** A sample_tick with playing=1 while in REQ, WAIT_DATA or ADVANCE pulses underrun.
  - It sets tick_pending, so the first lane is emitted in the cycle after the word is latched.
  - audio_data holds its last value meanwhile.
  - At most one tick is remembered.
- **Simultaneous events.** A command edge and a tick in the same cycle: the command is applied first, so the tick sees the new playing value. Pause wins over a tick.
- **Address arithmetic.** Wraps only at the range bounds; it never wraps modulo 2^ADDR_W.

## Timing
- Reset values:
  - flash_mem_read=0, flash_mem_address=START_ADDR, audio_data=0.
  - playing=0, direction=1, loop_en=LOOP_DEFAULT, underrun=0.
  - restart_pending=0, tick_pending=0.
  - The FSM is in REQ, so the first word is prefetched immediately after reset deasserts.
- Sample latency: audio_data updates on the clock edge after sample_tick (1 cycle).
- Refill: from ADVANCE, read is asserted the next cycle. A word must return within one tick period (≈2272 cycles at 22 kHz), otherwise underrun.
- Reset asserted mid-read: all outputs return to reset values asynchronously. Any in-flight readdatavalid after reset release is ignored unless the FSM is in WAIT_DATA.

## Test plan
- **Forward two-lane playback.** Reset, 'E', flash word at 0 = 32'hBBBB_AAAA.
  - Ticks 1 and 2 give audio_data AAAA then BBBB.
  - flash_mem_address becomes 1 and a read is issued before tick 3.
- **Backward order.** 'B' during word 5 = 32'h2222_1111.
  - Word 5 completes in forward order.
  - Word 4 is emitted high lane first; the address decrements.
- **Pause and resume.** 'D' between lanes: audio_data=0, ticks are ignored, the address is held. 'E' resumes with the held lane.
- **End-of-range boundary.** END_ADDR=3, START_ADDR=0.
  - loop_en=1: after word 3 the next read is at 0.
  - After 'L' (loop_en=0): after word 3, playing=0 and the address is 0.
- **Restart.** 'R' while backward at address 2: after the current word the address is END_ADDR, playing=1, restart_pending clears.
- **Underrun.** Hold waitrequest high for 3000 cycles during REQ.
  - underrun pulses once; flash_mem_read stays high with a stable address.
  - The first lane is emitted in the cycle after readdatavalid.
